// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I(+M) registered decode stage with one-entry skid buffer
// Purpose: decodes ir/pc_in into an execute bundle and registers it behind a
// valid/ready handshake. A one-entry skid buffer absorbs the instruction that
// arrives while execute is stalled, so in_ready is a flop output and
// back-pressure never forms a combinational path back to fetch.
// Ports:
//   clk, rst_n (asynchronous, active low), flush
//   in_valid/in_ready/ir/pc_in      : fetch side
//   out_valid/out_ready             : execute side handshake
//   srcreg*_num, dstreg_num, uses_rs*, imm, alucode, using_r2, using_pc,
//   write_reg, info_load/store/branch, is_muldiv, muldiv_op, illegal, pc_out
//                                   : registered decoded bundle
module decode_stage #(
    parameter int XLEN         = 32,
    parameter bit ENABLE_M     = 1'b1,
    parameter bit ILLEGAL_TRAP = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     ir,
    input  logic [XLEN-1:0] pc_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      srcreg1_num,
    output logic [4:0]      srcreg2_num,
    output logic [4:0]      dstreg_num,
    output logic            uses_rs1,
    output logic            uses_rs2,
    output logic [XLEN-1:0] imm,
    output logic [3:0]      alucode,
    output logic            using_r2,
    output logic            using_pc,
    output logic            write_reg,
    output logic [2:0]      info_load,
    output logic [1:0]      info_store,
    output logic [3:0]      info_branch,
    output logic            is_muldiv,
    output logic [2:0]      muldiv_op,
    output logic            illegal,
    output logic [XLEN-1:0] pc_out
);

    // Shared control encodings
    localparam logic [3:0] ALU_UNUSED = 4'd0;
    localparam logic [3:0] ALU_ADD    = 4'd1;
    localparam logic [3:0] ALU_SUB    = 4'd2;
    localparam logic [3:0] ALU_SLL    = 4'd3;
    localparam logic [3:0] ALU_SLT    = 4'd4;
    localparam logic [3:0] ALU_SLTU   = 4'd5;
    localparam logic [3:0] ALU_XOR    = 4'd6;
    localparam logic [3:0] ALU_SRL    = 4'd7;
    localparam logic [3:0] ALU_SRA    = 4'd8;
    localparam logic [3:0] ALU_OR     = 4'd9;
    localparam logic [3:0] ALU_AND    = 4'd10;
    localparam logic [3:0] ALU_LUI    = 4'd11;

    localparam logic [2:0] LD_NOT = 3'd0;
    localparam logic [2:0] LD_LB  = 3'd1;
    localparam logic [2:0] LD_LH  = 3'd2;
    localparam logic [2:0] LD_LW  = 3'd3;
    localparam logic [2:0] LD_LBU = 3'd4;
    localparam logic [2:0] LD_LHU = 3'd5;

    localparam logic [3:0] BR_NOT  = 4'd0;
    localparam logic [3:0] BR_BEQ  = 4'd1;
    localparam logic [3:0] BR_BNE  = 4'd2;
    localparam logic [3:0] BR_BLT  = 4'd3;
    localparam logic [3:0] BR_BGE  = 4'd4;
    localparam logic [3:0] BR_BLTU = 4'd5;
    localparam logic [3:0] BR_BGEU = 4'd6;
    localparam logic [3:0] BR_JAL  = 4'd7;
    localparam logic [3:0] BR_JALR = 4'd8;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [4:0]      srcreg1_num;
        logic [4:0]      srcreg2_num;
        logic [4:0]      dstreg_num;
        logic            uses_rs1;
        logic            uses_rs2;
        logic [XLEN-1:0] imm;
        logic [3:0]      alucode;
        logic            using_r2;
        logic            using_pc;
        logic            write_reg;
        logic [2:0]      info_load;
        logic [1:0]      info_store;
        logic [3:0]      info_branch;
        logic            is_muldiv;
        logic [2:0]      muldiv_op;
        logic            illegal;
        logic [XLEN-1:0] pc;
    } bundle_t;

    function automatic logic [3:0] alu_of_funct3(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic [2:0] load_of_funct3(input logic [2:0] f3);
        case (f3)
            3'b000:  return LD_LB;
            3'b001:  return LD_LH;
            3'b010:  return LD_LW;
            3'b100:  return LD_LBU;
            3'b101:  return LD_LHU;
            default: return LD_NOT;
        endcase
    endfunction

    function automatic logic [3:0] branch_of_funct3(input logic [2:0] f3);
        case (f3)
            3'b000:  return BR_BEQ;
            3'b001:  return BR_BNE;
            3'b100:  return BR_BLT;
            3'b101:  return BR_BGE;
            3'b110:  return BR_BLTU;
            3'b111:  return BR_BGEU;
            default: return BR_NOT;
        endcase
    endfunction

    // ---------------------------------------------------------------- decode
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_shamt;
    logic            legal;
    bundle_t         dec;

    assign opcode    = ir[6:0];
    assign funct3    = ir[14:12];
    assign funct7    = ir[31:25];
    assign imm_i     = XLEN'($signed(ir[31:20]));
    assign imm_s     = XLEN'($signed({ir[31:25], ir[11:7]}));
    assign imm_b     = XLEN'($signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}));
    assign imm_u     = XLEN'($signed({ir[31:12], 12'h000}));
    assign imm_j     = XLEN'($signed({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}));
    assign imm_shamt = XLEN'(ir[24:20]);

    always_comb begin
        dec             = '0;
        legal           = 1'b0;
        dec.srcreg1_num = ir[19:15];
        dec.srcreg2_num = ir[24:20];
        dec.dstreg_num  = ir[11:7];
        dec.pc          = pc_in;
        case (opcode)
            OPC_LUI: begin
                legal         = 1'b1;
                dec.imm       = imm_u;
                dec.alucode   = ALU_LUI;
                dec.write_reg = 1'b1;
            end
            OPC_AUIPC: begin
                legal         = 1'b1;
                dec.imm       = imm_u;
                dec.alucode   = ALU_ADD;
                dec.using_pc  = 1'b1;
                dec.write_reg = 1'b1;
            end
            OPC_JAL: begin
                legal           = 1'b1;
                dec.imm         = imm_j;
                dec.alucode     = ALU_ADD;
                dec.using_pc    = 1'b1;
                dec.write_reg   = 1'b1;
                dec.info_branch = BR_JAL;
            end
            OPC_JALR: begin
                legal           = (funct3 == 3'b000);
                dec.uses_rs1    = 1'b1;
                dec.imm         = imm_i;
                dec.alucode     = ALU_ADD;
                dec.write_reg   = 1'b1;
                dec.info_branch = BR_JALR;
            end
            OPC_BRANCH: begin
                // funct3 010/011 are unassigned branch encodings
                legal           = (funct3[2:1] != 2'b01);
                dec.dstreg_num  = 5'd0;
                dec.uses_rs1    = 1'b1;
                dec.uses_rs2    = 1'b1;
                dec.imm         = imm_b;
                dec.alucode     = ALU_ADD;
                dec.using_pc    = 1'b1;
                dec.info_branch = branch_of_funct3(funct3);
            end
            OPC_LOAD: begin
                legal         = (funct3 != 3'b011) && (funct3[2:1] != 2'b11);
                dec.uses_rs1  = 1'b1;
                dec.imm       = imm_i;
                dec.alucode   = ALU_ADD;
                dec.write_reg = 1'b1;
                dec.info_load = load_of_funct3(funct3);
            end
            OPC_STORE: begin
                legal          = (funct3 <= 3'd2);
                dec.dstreg_num = 5'd0;
                dec.uses_rs1   = 1'b1;
                dec.uses_rs2   = 1'b1;
                dec.imm        = imm_s;
                dec.alucode    = ALU_ADD;
                dec.info_store = funct3[1:0] + 2'd1;
            end
            OPC_OPIMM: begin
                dec.uses_rs1  = 1'b1;
                dec.write_reg = 1'b1;
                if (funct3 == 3'b001) begin
                    legal       = (funct7 == 7'b0000000);
                    dec.imm     = imm_shamt;
                    dec.alucode = ALU_SLL;
                end else if (funct3 == 3'b101) begin
                    legal       = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                    dec.imm     = imm_shamt;
                    dec.alucode = funct7[5] ? ALU_SRA : ALU_SRL;
                end else begin
                    legal       = 1'b1;
                    dec.imm     = imm_i;
                    dec.alucode = alu_of_funct3(funct3);
                end
            end
            OPC_OP: begin
                dec.uses_rs1  = 1'b1;
                dec.uses_rs2  = 1'b1;
                dec.using_r2  = 1'b1;
                dec.write_reg = 1'b1;
                if (funct7 == 7'b0000000) begin
                    legal       = 1'b1;
                    dec.alucode = alu_of_funct3(funct3);
                end else if (funct7 == 7'b0100000) begin
                    legal       = (funct3 == 3'b000) || (funct3 == 3'b101);
                    dec.alucode = (funct3 == 3'b000) ? ALU_SUB : ALU_SRA;
                end else if (ENABLE_M && (funct7 == 7'b0000001)) begin
                    legal         = 1'b1;
                    dec.is_muldiv = 1'b1;
                    dec.muldiv_op = funct3;
                end
            end
            // FENCE and SYSTEM retire as NOPs: every control field stays zero
            OPC_FENCE, OPC_SYSTEM: legal = 1'b1;
            default: legal = 1'b0;
        endcase

        // An undecodable word keeps only its register fields and PC so the
        // trap handler can still report it; everything that acts is cleared.
        if (!legal) begin
            dec.uses_rs1    = 1'b0;
            dec.uses_rs2    = 1'b0;
            dec.imm         = '0;
            dec.alucode     = ALU_UNUSED;
            dec.using_r2    = 1'b0;
            dec.using_pc    = 1'b0;
            dec.write_reg   = 1'b0;
            dec.info_load   = LD_NOT;
            dec.info_store  = 2'd0;
            dec.info_branch = BR_NOT;
            dec.is_muldiv   = 1'b0;
            dec.muldiv_op   = 3'd0;
            dec.illegal     = ILLEGAL_TRAP;
        end
        if (dec.dstreg_num == 5'd0) dec.write_reg = 1'b0;
    end

    // -------------------------------------------------------------- pipeline
    bundle_t out_q, out_d, skid_q, skid_d;
    logic    out_valid_q, out_valid_d;
    logic    skid_valid_q, skid_valid_d;
    logic    in_ready_q, in_ready_d;
    logic    accept, load_out;

    assign accept   = in_valid && in_ready_q;
    assign load_out = !out_valid_q || out_ready;

    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d       = 1'b0;
            skid_valid_d      = 1'b0;
            out_d.write_reg   = 1'b0;
            out_d.info_load   = LD_NOT;
            out_d.info_store  = 2'd0;
            out_d.info_branch = BR_NOT;
        end else if (load_out) begin
            // in_ready_q is low whenever the skid is full, so no accept can
            // collide with a drain.
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = accept;
                if (accept) out_d = dec;
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign srcreg1_num = out_q.srcreg1_num;
    assign srcreg2_num = out_q.srcreg2_num;
    assign dstreg_num  = out_q.dstreg_num;
    assign uses_rs1    = out_q.uses_rs1;
    assign uses_rs2    = out_q.uses_rs2;
    assign imm         = out_q.imm;
    assign alucode     = out_q.alucode;
    assign using_r2    = out_q.using_r2;
    assign using_pc    = out_q.using_pc;
    assign write_reg   = out_q.write_reg;
    assign info_load   = out_q.info_load;
    assign info_store  = out_q.info_store;
    assign info_branch = out_q.info_branch;
    assign is_muldiv   = out_q.is_muldiv;
    assign muldiv_op   = out_q.muldiv_op;
    assign illegal     = out_q.illegal;
    assign pc_out      = out_q.pc;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage
module tb_decode_stage;

    localparam logic [3:0] A_UNUSED = 4'd0, A_ADD = 4'd1, A_SUB = 4'd2, A_SLL = 4'd3,
                           A_SLT = 4'd4, A_SLTU = 4'd5, A_XOR = 4'd6, A_SRL = 4'd7,
                           A_SRA = 4'd8, A_OR = 4'd9, A_AND = 4'd10, A_LUI = 4'd11;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        ur1;
        logic        ur2;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic        sel_r2;
        logic        sel_pc;
        logic        wr;
        logic [2:0]  ld;
        logic [1:0]  st;
        logic [3:0]  br;
        logic        md;
        logic [2:0]  mop;
        logic        ill;
        logic [31:0] pc;
    } bundle_t;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] pc;
    } item_t;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] ir, pc_in;

    // Three instances: [0] full config, [1] ENABLE_M=0, [2] ILLEGAL_TRAP=0
    logic        in_ready_w [3];
    logic        out_valid_w[3];
    logic [4:0]  rs1_w[3], rs2_w[3], rd_w[3];
    logic        ur1_w[3], ur2_w[3];
    logic [31:0] imm_w[3];
    logic [3:0]  alu_w[3];
    logic        sel_r2_w[3], sel_pc_w[3], wr_w[3];
    logic [2:0]  ld_w[3];
    logic [1:0]  st_w[3];
    logic [3:0]  br_w[3];
    logic        md_w[3];
    logic [2:0]  mop_w[3];
    logic        ill_w[3];
    logic [31:0] pco_w[3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        decode_stage #(.XLEN(32), .ENABLE_M(g != 1), .ILLEGAL_TRAP(g != 2)) u_dut (
            .clk(clk), .rst_n(rst_n), .flush(flush),
            .in_valid(in_valid), .in_ready(in_ready_w[g]),
            .ir(ir), .pc_in(pc_in),
            .out_valid(out_valid_w[g]), .out_ready(out_ready),
            .srcreg1_num(rs1_w[g]), .srcreg2_num(rs2_w[g]), .dstreg_num(rd_w[g]),
            .uses_rs1(ur1_w[g]), .uses_rs2(ur2_w[g]), .imm(imm_w[g]),
            .alucode(alu_w[g]), .using_r2(sel_r2_w[g]), .using_pc(sel_pc_w[g]),
            .write_reg(wr_w[g]), .info_load(ld_w[g]), .info_store(st_w[g]),
            .info_branch(br_w[g]), .is_muldiv(md_w[g]), .muldiv_op(mop_w[g]),
            .illegal(ill_w[g]), .pc_out(pco_w[g])
        );
    end

    int          checks = 0;
    int          failures = 0;
    item_t       q[$];
    logic [31:0] pc_next = 32'h0000_1000;
    logic [31:0] pc1, pc2, pc3;

    task automatic chk1(input string tag, input logic o, input logic e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, o, e);
        end
    endtask

    task automatic chkv(input string tag, input logic [127:0] o, input logic [127:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    function automatic logic [3:0] alu_table(input logic [2:0] f3);
        logic [3:0] t[8];
        t = '{A_ADD, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_OR, A_AND};
        return t[f3];
    endfunction

    // Reference decoder written straight from the ISA rules
    function automatic bundle_t ref_decode(input logic [31:0] w, input logic [31:0] pc,
                                           input bit en_m, input bit trap);
        bundle_t     b, c;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] i_imm;
        bit          ok;
        b = '0; f3 = w[14:12]; f7 = w[31:25]; ok = 0;
        i_imm = {{20{w[31]}}, w[31:20]};
        b.rs1 = w[19:15]; b.rs2 = w[24:20]; b.rd = w[11:7]; b.pc = pc;
        case (w[6:0])
            7'h37: begin ok = 1; b.imm = {w[31:12], 12'h000}; b.alu = A_LUI; b.wr = 1; end
            7'h17: begin ok = 1; b.imm = {w[31:12], 12'h000}; b.alu = A_ADD; b.sel_pc = 1; b.wr = 1; end
            7'h6f: begin
                ok = 1; b.imm = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
                b.alu = A_ADD; b.sel_pc = 1; b.wr = 1; b.br = 4'd7;
            end
            7'h67: begin ok = (f3 == 3'd0); b.ur1 = 1; b.imm = i_imm; b.alu = A_ADD; b.wr = 1; b.br = 4'd8; end
            7'h63: begin
                b.rd = 0;
                ok = f3 inside {3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
                b.ur1 = 1; b.ur2 = 1; b.alu = A_ADD; b.sel_pc = 1;
                b.imm = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
                case (f3)
                    3'd0: b.br = 4'd1; 3'd1: b.br = 4'd2; 3'd4: b.br = 4'd3;
                    3'd5: b.br = 4'd4; 3'd6: b.br = 4'd5; default: b.br = 4'd6;
                endcase
            end
            7'h03: begin
                ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
                b.ur1 = 1; b.imm = i_imm; b.alu = A_ADD; b.wr = 1;
                b.ld = (f3 == 3'd4) ? 3'd4 : (f3 == 3'd5) ? 3'd5 : f3 + 3'd1;
            end
            7'h23: begin
                b.rd = 0; ok = (f3 < 3'd3); b.ur1 = 1; b.ur2 = 1; b.alu = A_ADD;
                b.imm = {{20{w[31]}}, w[31:25], w[11:7]}; b.st = f3[1:0] + 2'd1;
            end
            7'h13: begin
                b.ur1 = 1; b.wr = 1;
                if (f3 == 3'd1) begin
                    ok = (f7 == 7'h00); b.imm = 32'(w[24:20]); b.alu = A_SLL;
                end else if (f3 == 3'd5) begin
                    ok = f7 inside {7'h00, 7'h20}; b.imm = 32'(w[24:20]);
                    b.alu = (f7 == 7'h20) ? A_SRA : A_SRL;
                end else begin
                    ok = 1; b.imm = i_imm; b.alu = alu_table(f3);
                end
            end
            7'h33: begin
                b.ur1 = 1; b.ur2 = 1; b.sel_r2 = 1; b.wr = 1;
                if (f7 == 7'h00) begin
                    ok = 1; b.alu = alu_table(f3);
                end else if (f7 == 7'h20) begin
                    ok = f3 inside {3'd0, 3'd5}; b.alu = (f3 == 3'd0) ? A_SUB : A_SRA;
                end else if (f7 == 7'h01 && en_m) begin
                    ok = 1; b.md = 1; b.mop = f3; b.alu = A_UNUSED;
                end
            end
            7'h0f, 7'h73: ok = 1;
            default: ok = 0;
        endcase
        if (!ok) begin
            c = '0; c.rs1 = b.rs1; c.rs2 = b.rs2; c.rd = b.rd; c.pc = pc; c.ill = trap;
            b = c;
        end
        if (b.rd == 5'd0) b.wr = 0;
        return b;
    endfunction

    function automatic bundle_t obs(input int g);
        bundle_t b;
        b.rs1 = rs1_w[g]; b.rs2 = rs2_w[g]; b.rd = rd_w[g]; b.ur1 = ur1_w[g]; b.ur2 = ur2_w[g];
        b.imm = imm_w[g]; b.alu = alu_w[g]; b.sel_r2 = sel_r2_w[g]; b.sel_pc = sel_pc_w[g];
        b.wr = wr_w[g]; b.ld = ld_w[g]; b.st = st_w[g]; b.br = br_w[g]; b.md = md_w[g];
        b.mop = mop_w[g]; b.ill = ill_w[g]; b.pc = pco_w[g];
        return b;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        logic [6:0]  f7;
        w = $urandom;
        case ($urandom_range(0, 3))
            0: f7 = 7'h00; 1: f7 = 7'h20; 2: f7 = 7'h01; default: f7 = w[31:25];
        endcase
        case ($urandom_range(0, 10))
            0: w = {f7, w[24:7], 7'h13};
            1: w = {f7, w[24:7], 7'h33};
            2: w[6:0] = 7'h03;
            3: w[6:0] = 7'h23;
            4: w[6:0] = 7'h63;
            5: w[6:0] = 7'h6f;
            6: begin w[6:0] = 7'h67; if ($urandom_range(0, 1) == 0) w[14:12] = 3'd0; end
            7: w[6:0] = 7'h37;
            8: w[6:0] = 7'h17;
            9: w[6:0] = ($urandom_range(0, 1) == 0) ? 7'h0f : 7'h73;
            default: ;
        endcase
        return w;
    endfunction

    task automatic put(input logic [31:0] w);
        ir = w; pc_in = pc_next; pc_next = pc_next + 32'd4; in_valid = 1'b1;
    endtask

    // One clock: handshakes and the held-item count are judged at the negedge,
    // the model is updated just after the posedge.
    task automatic step();
        bit acc, cons;
        @(negedge clk);
        acc  = in_valid && in_ready_w[0];
        cons = out_valid_w[0] && out_ready && !flush;
        chk1("in_ready_vs_held", in_ready_w[0], q.size() < 2);
        chk1("out_valid_vs_held", out_valid_w[0], q.size() > 0);
        if (cons && q.size() > 0)
            for (int g = 0; g < 3; g++)
                chkv($sformatf("bundle_dut%0d", g), 128'(obs(g)),
                     128'(ref_decode(q[0].ir, q[0].pc, g != 1, g != 2)));
        @(posedge clk);
        #1;
        if (flush) q.delete();
        else begin
            if (cons && q.size() > 0) void'(q.pop_front());
            if (acc) q.push_back('{ir: ir, pc: pc_in});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; ir = '0; pc_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk1("reset_out_valid", out_valid_w[0], 1'b0);
        chk1("reset_in_ready", in_ready_w[0], 1'b1);
        chkv("reset_bundle", 128'(obs(0)), 128'(0));
        rst_n = 1'b1;

        // addi x1,x0,5
        out_ready = 1'b1;
        put(32'h0050_0093);
        step();
        in_valid = 1'b0;
        chk1("addi_out_valid", out_valid_w[0], 1'b1);
        chkv("addi_alucode", 128'(alu_w[0]), 128'(A_ADD));
        chkv("addi_imm", 128'(imm_w[0]), 128'(32'd5));
        chkv("addi_rd", 128'(rd_w[0]), 128'(5'd1));
        chk1("addi_write_reg", wr_w[0], 1'b1);
        chk1("addi_uses_rs1", ur1_w[0], 1'b1);
        chk1("addi_uses_rs2", ur2_w[0], 1'b0);
        step();

        // back-pressure: second goes to skid, third waits at the input
        out_ready = 1'b0;
        put(32'h0010_0113); pc1 = pc_in; step();
        put(32'h0020_0193); pc2 = pc_in; step();
        chk1("skid_full_in_ready", in_ready_w[0], 1'b0);
        put(32'h0030_0213); pc3 = pc_in; step();
        step();
        chkv("stall_head_pc", 128'(pco_w[0]), 128'(pc1));
        out_ready = 1'b1;
        step();
        chkv("drain_pc", 128'(pco_w[0]), 128'(pc2));
        chk1("drain_in_ready", in_ready_w[0], 1'b1);
        step();
        in_valid = 1'b0;
        chkv("third_pc", 128'(pco_w[0]), 128'(pc3));
        step();

        // flush with the skid full, plus an input offered in the flush cycle
        out_ready = 1'b0;
        put(32'h0000_8093); step();
        put(32'h0011_0113); step();
        flush = 1'b1;
        put(32'h0021_8193); step();
        flush = 1'b0; in_valid = 1'b0;
        chk1("flush_out_valid", out_valid_w[0], 1'b0);
        chk1("flush_in_ready", in_ready_w[0], 1'b1);
        chk1("flush_write_reg", wr_w[0], 1'b0);
        chkv("flush_info_branch", 128'(br_w[0]), 128'(4'd0));
        out_ready = 1'b1;
        put(32'h0040_0293); pc1 = pc_in; step();
        in_valid = 1'b0;
        chk1("post_flush_valid", out_valid_w[0], 1'b1);
        chkv("post_flush_pc", 128'(pco_w[0]), 128'(pc1));
        step();

        // SLL with funct7 0100000
        put(32'h4000_1033); step();
        chk1("sll_alt_illegal", ill_w[0], 1'b1);
        chk1("sll_alt_write_reg", wr_w[0], 1'b0);
        chk1("sll_alt_notrap_illegal", ill_w[2], 1'b0);
        chkv("sll_alt_notrap_alucode", 128'(alu_w[2]), 128'(A_UNUSED));
        chk1("sll_alt_notrap_write_reg", wr_w[2], 1'b0);

        // mul x0,x1,x2
        put(32'h0220_8033); step();
        chk1("mul_is_muldiv", md_w[0], 1'b1);
        chkv("mul_op", 128'(mop_w[0]), 128'(3'd0));
        chk1("mul_write_reg", wr_w[0], 1'b0);
        chk1("mul_noM_illegal", ill_w[1], 1'b1);

        // srai x1,x1,31 then an asynchronous reset between edges
        put(32'h41F0_D093); step();
        in_valid = 1'b0;
        chkv("srai_alucode", 128'(alu_w[0]), 128'(A_SRA));
        chkv("srai_imm", 128'(imm_w[0]), 128'(32'd31));
        chk1("srai_valid_before_reset", out_valid_w[0], 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        for (int g = 0; g < 3; g++) chk1($sformatf("async_reset_valid%0d", g), out_valid_w[g], 1'b0);
        chk1("async_reset_in_ready", in_ready_w[0], 1'b1);
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // randomized traffic against the reference model
        for (int n = 0; n < 600; n++) begin
            flush     = ($urandom_range(0, 29) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) != 0) put(gen_instr());
            else in_valid = 1'b0;
            step();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered RV32I(+M) instruction-decode pipeline stage between fetch and execute.
- Adds a valid/ready handshake with a one-entry skid buffer, so in_ready is a flop output and back-pressure does not create a combinational path back to fetch.
- Adds illegal-instruction detection, optional M-extension decode and source-usage flags for the hazard unit.
- Control encodings (alucode, info_load, info_store, info_branch, TRUE/FALSE) come from the shared 99_define.v header.

Parameters:
- XLEN, 32, width of pc_in, pc_out and imm; immediates are sign-extended to XLEN.
- ENABLE_M, 1, when 1, decode opcode 0110011 with funct7 0000001 as MUL/DIV; when 0, treat it as illegal.
- ILLEGAL_TRAP, 1, when 1, drive the illegal output; when 0, tie illegal to 0 and decode illegal encodings as NOP.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  discard all held and incoming instructions.
- in_valid  in  1  ir/pc_in carry an instruction.
- in_ready  out  1  stage can accept; registered.
- ir  in  32  instruction word.
- pc_in  in  XLEN  PC of ir.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute consumes bundle.
- srcreg1_num, srcreg2_num, dstreg_num  out  5 each  register numbers.
- uses_rs1, uses_rs2  out  1 each  instruction reads rs1/rs2.
- imm  out  XLEN  decoded immediate.
- alucode  out  4  ALU operation.
- using_r2, using_pc  out  1 each  ALU operand selects.
- write_reg  out  1  register write enable.
- info_load  out  3  load type.
- info_store  out  2  store type.
- info_branch  out  4  branch/jump type.
- is_muldiv  out  1  instruction is M-extension.
- muldiv_op  out  3  funct3 of M instruction.
- illegal  out  1  undecodable instruction.
- pc_out  out  XLEN  PC of the decoded bundle.

Behaviour:
- Reset (rst_n=0, async):
  - out_valid=0, skid empty, in_ready=1.
  - All bundle outputs 0; alucode=UNUSED, info_*=NOT*.
- Accept: the stage takes an instruction when in_valid&&in_ready.
- Output register load: the output register loads when (!out_valid || out_ready).
  - Source is the skid entry if the skid is full; otherwise the accepted input, which gives 1-cycle latency.
- Skid fill: when an input is accepted while out_valid && !out_ready, the decoded result goes to the skid and in_ready goes to 0 the next cycle.
- Skid drain: the skid drains into the output register on the first cycle with out_ready=1; in_ready returns to 1 the next cycle.
- Ordering and loss: no instruction is lost or duplicated, and program order is preserved.
- Simultaneous accept and consume with the skid empty: the new instruction goes directly to the output register and out_valid stays 1.
- Flush:
  - Next cycle: out_valid=0, skid emptied, in_ready=1.
  - Any input accepted in the flush cycle is discarded.
  - Bundle fields are not cleared except info_*=NOT* and write_reg=0.
  - Flush overrides in_valid and out_ready.
- Decode (performed before registration):
  - I-type: imm is sign-extended ir[31:20].
    - SLLI requires funct7=0000000; SRLI/SRAI require funct7 of 0000000 or 0100000, otherwise illegal.
    - For all shift-immediates, imm = zero-extended ir[24:20].
  - R-type funct7 rules:
    - 0000000 is legal for all funct3.
    - 0100000 is legal only for ADD/SUB and SRL/SRA.
    - 0000001 is M-extension when ENABLE_M=1: is_muldiv=1, muldiv_op=funct3, alucode=UNUSED.
    - Any other funct7 is illegal.
  - LUI/AUIPC/JAL/JALR/branch/load/store: immediate formats and operand selects as in the current pipeline.
  - Load/store legality:
    - Loads with funct3 011, 110 or 111 are illegal.
    - Stores with funct3 above 010 are illegal.
    - Branches with funct3 010 or 011 are illegal.
    - JALR with funct3≠000 is illegal.
  - FENCE (0001111) and SYSTEM (1110011) decode as NOP: write_reg=0, illegal=0.
  - Illegal instruction, including an unknown opcode: illegal=1 (if ILLEGAL_TRAP), write_reg=0, info_*=NOT*, alucode=UNUSED.
  - write_reg is forced to 0 when dstreg_num=0.
  - dstreg_num is 0 for branch and store.
  - uses_rs1 is 0 for LUI/AUIPC/JAL/FENCE/SYSTEM/illegal.
  - uses_rs2 is 1 only for R-type, branch and store.
  - pc_out = pc_in of the same instruction.

Test Plan:
1. Reset, then ir=0x00500093 (addi x1,x0,5), in_valid=1, out_ready=1 -> next cycle: out_valid=1, alucode=ADD, imm=5, dstreg_num=1, write_reg=1, uses_rs1=1, uses_rs2=0.
2. Hold out_ready=0; send 3 instructions back-to-back -> the 2nd goes to the skid and in_ready=0 from the cycle after it; the 3rd is held at the input. Release out_ready -> bundles appear in order 1,2,3 with no gaps beyond one cycle.
3. Skid full plus flush -> next cycle out_valid=0, in_ready=1; the following input appears after 1 cycle with no stale bundle.
4. ir=0x40001033 (funct7 0100000, SLL) -> illegal=1, write_reg=0. With ILLEGAL_TRAP=0 -> illegal=0 and the instruction decodes as NOP.
5. ir=0x02208033 (mul x0,x1,x2): ENABLE_M=1 -> is_muldiv=1, muldiv_op=0, write_reg=0 (rd=x0). ENABLE_M=0 -> illegal=1.
6. ir=0x41F0D093 (srai x1,x1,31) -> alucode=SRA, imm=31. Assert rst_n low mid-stream -> out_valid=0 immediately, without waiting for a clock edge.
